buf_page_reader: RTL and testbench
==================================

BUF_PAGE_READER -- requirements
Module: buf_page_reader

Interface
- REQ-001 Parameter ADDR_W, default 11, buffer address width (2048-byte page buffer).
- REQ-002 Parameter DATA_W, default 8, byte width of buffer and output stream.
- REQ-003 Clock  in  1  sole clock; all logic on rising edge.
- REQ-004 Reset  in  1  synchronous, active-high reset.
- REQ-005 Start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- REQ-006 StartAddr  in  ADDR_W  first buffer address of the transfer.
- REQ-007 Length  in  ADDR_W+1  byte count, 0..4095 accepted.
- REQ-008 Abort  in  1  terminate the current transfer.
- REQ-009 Busy  out  1  high from the cycle after Start is accepted until Done.
- REQ-010 Done  out  1  one-cycle pulse at end of transfer, whether completed or aborted.
- REQ-011 BufAddr  out  ADDR_W  read address to buffer port B.
- REQ-012 BufClkEn  out  1  read enable (ClockEn) to buffer port B.
- REQ-013 BufWr  out  1  write strobe to port B; constant 0.
- REQ-014 BufQ  in  DATA_W  buffer port B read data; valid the cycle after BufClkEn.
- REQ-015 DOut  out  DATA_W  streamed byte toward the NAND program path.
- REQ-016 DValid  out  1  DOut holds a valid byte.
- REQ-017 DReady  in  1  consumer accepts; byte transferred when DValid && DReady.

Function
- REQ-018 FSM states IDLE, STREAM, DRAIN, FIN; IDLE->STREAM on Start; STREAM->DRAIN when last read issued; DRAIN->FIN when last byte accepted; FIN->IDLE unconditionally after one cycle with Done=1.
- REQ-019 Start accepted at edge N: BufClkEn=1 with BufAddr=StartAddr during cycle N+1; first DValid=1 in cycle N+2.
- REQ-020 Buffer read latency: exactly 1 cycle; returned BufQ captured into a 2-entry output FIFO; DOut/DValid driven from FIFO head.
- REQ-021 Read issued only when (FIFO occupancy + reads in flight) < 2; no returned byte is ever dropped.
- REQ-022 With DReady held high: one byte per cycle sustained, no bubbles after the first.
- REQ-023 DOut and DValid stable while DValid && !DReady.
- REQ-024 BufAddr increments by 1 per issued read, wrapping 2^ADDR_W-1 -> 0.
- REQ-025 Length > 2^ADDR_W saturates to 2^ADDR_W; exactly that many bytes emitted.
- REQ-026 Length = 0: no reads, DValid never asserted, Done pulses in cycle N+2.
- REQ-027 Abort in STREAM or DRAIN: no further reads issued; FIFO and in-flight data discarded; DValid=0 next cycle; FIN next cycle, Done pulse, then IDLE.
- REQ-028 Abort in IDLE or FIN ignored; Start outside IDLE ignored; Start and Abort together in IDLE -> Start wins.
- REQ-029 Bytes emitted in address order; DOut k equals buffer[(StartAddr+k) mod 2^ADDR_W].

Reset
- REQ-030 Reset forces IDLE; Busy=0, Done=0, DValid=0, BufClkEn=0, BufWr=0, BufAddr=0, DOut=0, FIFO empty, counters 0.
- REQ-031 Reset mid-transfer: all state cleared next edge, no Done pulse, in-flight read data discarded.

Structure
- REQ-032 Shared package nand_buf_pkg holds ADDR_W, DATA_W, PAGE_BYTES and the FSM state enum.
- REQ-033 Single sub-module buf_skid_fifo (2-entry, valid/ready, occupancy output) instantiated once.

Verification
- REQ-034 Preload buffer[i]=i mod 256; Start, StartAddr=0, Length=16, DReady=1 -> DOut 0..15 in consecutive cycles from N+2, one Done pulse, Busy low after.
- REQ-035 StartAddr=2044, Length=8 -> BufAddr 2044..2047,0..3; DOut 252,253,254,255,0,1,2,3.
- REQ-036 Length=64, DReady toggled by random pattern -> 64 in-order bytes, DOut stable during stalls, BufClkEn never issued with 2 bytes held.
- REQ-037 Length=0 -> no DValid, Done at N+2; Length=4095 -> exactly 2048 bytes.
- REQ-038 Abort after 10 bytes accepted of Length=100 -> DValid=0 next cycle, Done once, next Start/StartAddr=0/Length=4 emits 0,1,2,3.
- REQ-039 Reset asserted mid-transfer (byte 5 of 32) -> all outputs at reset values, no Done; subsequent transfer correct.

Source files
------------

// File: rtl/nand_buf_pkg.sv
// rtl/nand_buf_pkg.sv - shared page-buffer geometry and reader FSM state encoding
package nand_buf_pkg;

  localparam int BUF_ADDR_W = 11;
  localparam int BUF_DATA_W = 8;
  localparam int PAGE_BYTES = 1 << BUF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FIN    = 2'd3
  } rd_state_e;

endpackage

// File: rtl/buf_skid_fifo.sv
// rtl/buf_skid_fifo.sv - 2-entry fall-through FIFO; an empty FIFO presents incoming data the same cycle
module buf_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  input  logic              m_tready,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              push;
  logic              pop;

  // Incoming data is only stored when it cannot leave straight through
  assign push     = s_tvalid && !((count == 2'd0) && m_tready);
  assign pop      = (count != 2'd0) && m_tready;
  assign wr_ptr   = rd_ptr ^ count[0];
  assign m_tvalid = (count != 2'd0) || s_tvalid;

  always_comb begin
    m_tdata = '0;
    if (count != 2'd0) m_tdata = mem[rd_ptr];
    else if (s_tvalid) m_tdata = s_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= s_tdata;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/buf_page_reader.sv
// rtl/buf_page_reader.sv - streams a byte range of the page buffer toward the NAND program path
module buf_page_reader
  import nand_buf_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   Length,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] BufAddr,
  output logic              BufClkEn,
  output logic              BufWr,
  input  logic [DATA_W-1:0] BufQ,
  output logic [DATA_W-1:0] DOut,
  output logic              DValid,
  input  logic              DReady
);

  localparam logic [1:0]      IDLE     = ST_IDLE;
  localparam logic [1:0]      STREAM   = ST_STREAM;
  localparam logic [1:0]      DRAIN    = ST_DRAIN;
  localparam logic [1:0]      FIN      = ST_FIN;
  localparam logic [ADDR_W:0] PAGE_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [ADDR_W:0] rd_left;
  logic [ADDR_W:0] emit_left;
  logic [ADDR_W:0] len_sat;
  logic            in_flight;
  logic [1:0]      fifo_count;
  logic            active;
  logic            issue;
  logic            accept;
  logic            last_out;

  assign len_sat  = (Length > PAGE_LEN) ? PAGE_LEN : Length;
  assign active   = (state == STREAM) || (state == DRAIN);
  assign accept   = DValid && DReady;
  assign last_out = (emit_left == '0) || ((emit_left == ONE) && accept);

  // Held bytes plus the read still in the RAM pipeline must leave room for the new one
  assign issue = (state == STREAM) && !Abort && (rd_left != '0) &&
                 (({1'b0, fifo_count} + {2'b00, in_flight}) < 3'd2);

  assign BufClkEn = issue;
  assign BufWr    = 1'b0;
  assign Busy     = (state != IDLE);
  assign Done     = (state == FIN);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      BufAddr   <= '0;
      rd_left   <= '0;
      emit_left <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        BufAddr <= BufAddr + ADDR_W'(1);
        rd_left <= rd_left - ONE;
      end
      if (accept) emit_left <= emit_left - ONE;
      case (state)
        IDLE: if (Start) begin
          state     <= STREAM;
          BufAddr   <= StartAddr;
          rd_left   <= len_sat;
          emit_left <= len_sat;
        end
        STREAM: begin
          if (Abort) state <= FIN;
          else if (rd_left == '0) state <= last_out ? FIN : DRAIN;
          else if (issue && (rd_left == ONE)) state <= DRAIN;
        end
        DRAIN:   if (Abort || last_out) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // An abort discards both the stored bytes and whatever the RAM returns this cycle
  buf_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .flush    (Abort && active),
    .s_tvalid (in_flight),
    .s_tdata  (BufQ),
    .m_tvalid (DValid),
    .m_tdata  (DOut),
    .m_tready (DReady),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_buf_page_reader.sv
// tb/tb_buf_page_reader.sv - randomized self-checking bench for buf_page_reader
module tb_buf_page_reader;

  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int PAGE = 2048;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          DReady = 1'b1;
  logic [AW-1:0] StartAddr = '0;
  logic [AW:0]   Length = '0;
  logic [DW-1:0] BufQ = '0;
  logic          Busy, Done, BufClkEn, BufWr, DValid;
  logic [AW-1:0] BufAddr;
  logic [DW-1:0] DOut;

  buf_page_reader dut (
    .Clock(clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Length(Length),
    .Abort(Abort), .Busy(Busy), .Done(Done), .BufAddr(BufAddr), .BufClkEn(BufClkEn),
    .BufWr(BufWr), .BufQ(BufQ), .DOut(DOut), .DValid(DValid), .DReady(DReady)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [PAGE];
  always @(posedge clk) if (BufClkEn) BufQ <= mem[BufAddr];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_edge = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt, dv_cnt, done_rel, first_dv_rel, first_iss_rel, acc_first_rel, acc_last_rel;
  int stall_viol, held_viol, issued, accepted;
  logic [7:0] acc_q[$];
  int iss_q[$];
  logic prev_stall;
  logic [7:0] prev_dout;

  always @(negedge clk) begin
    if (Done) begin done_cnt++; done_rel = cyc - n_edge; end
    if (DValid) begin dv_cnt++; if (first_dv_rel < 0) first_dv_rel = cyc - n_edge; end
    if (BufClkEn) begin
      if (issued - accepted >= 2) held_viol++;
      if (first_iss_rel < 0) first_iss_rel = cyc - n_edge;
      iss_q.push_back(int'(BufAddr));
      issued++;
    end
    if (prev_stall && (!DValid || DOut !== prev_dout)) stall_viol++;
    if (DValid && DReady) begin
      acc_q.push_back(DOut);
      accepted++;
      if (acc_first_rel < 0) acc_first_rel = cyc - n_edge;
      acc_last_rel = cyc - n_edge;
    end
    prev_stall = DValid && !DReady;
    prev_dout  = DOut;
  end

  function automatic int first_bad(input int sa, input int n);
    for (int k = 0; k < n && k < acc_q.size(); k++)
      if (acc_q[k] !== mem[(sa + k) % PAGE]) return k;
    return -1;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < PAGE; i++) mem[i] = 8'(i % 256);
  endtask

  task automatic fill_random();
    for (int i = 0; i < PAGE; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_xfer(input int sa, input int len);
    @(posedge clk); #1;
    done_cnt = 0; dv_cnt = 0; done_rel = -1; first_dv_rel = -1; first_iss_rel = -1;
    acc_first_rel = -1; acc_last_rel = -1; stall_viol = 0; held_viol = 0;
    issued = 0; accepted = 0; prev_stall = 1'b0;
    acc_q.delete(); iss_q.delete();
    DReady = 1'b1; Start = 1'b1; StartAddr = AW'(sa); Length = (AW+1)'(len);
    n_edge = cyc + 1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) DReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({Busy, Done, DValid, BufClkEn, BufWr} !== 5'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 00000", {Busy, Done, DValid, BufClkEn, BufWr}); end
    n_checks++; if (BufAddr !== '0) begin n_errors++; $display("FAIL reset_bufaddr: got %0d expected 0", BufAddr); end
    n_checks++; if (DOut !== '0) begin n_errors++; $display("FAIL reset_dout: got %0d expected 0", DOut); end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    fill_ramp();
    start_xfer(0, 16);
    wait_done(100, 1'b0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: got no Done expected Done"); end
    n_checks++; if (first_iss_rel !== 0 || iss_q.size() == 0 || iss_q[0] !== 0) begin n_errors++; $display("FAIL basic_first_read: got rel %0d expected rel 0 addr 0", first_iss_rel); end
    n_checks++; if (first_dv_rel !== 1) begin n_errors++; $display("FAIL basic_first_dvalid: got rel %0d expected 1", first_dv_rel); end
    n_checks++; if (acc_q.size() !== 16) begin n_errors++; $display("FAIL basic_count: got %0d expected 16", acc_q.size()); end
    n_checks++; if (first_bad(0, 16) !== -1) begin n_errors++; $display("FAIL basic_data: got bad index %0d expected -1", first_bad(0, 16)); end
    n_checks++; if (acc_last_rel - acc_first_rel !== 15) begin n_errors++; $display("FAIL basic_no_bubbles: got span %0d expected 15", acc_last_rel - acc_first_rel); end
    @(negedge clk); @(negedge clk);
    n_checks++; if (done_cnt !== 1 || Busy !== 1'b0) begin n_errors++; $display("FAIL basic_done_busy: got done %0d busy %b expected 1 0", done_cnt, Busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    start_xfer(2044, 8);
    wait_done(100, 1'b0, ok);
    bad = (iss_q.size() == 8) ? -1 : 99;
    for (int k = 0; k < 8 && k < iss_q.size(); k++)
      if (bad < 0 && iss_q[k] !== (2044 + k) % PAGE) bad = k;
    n_checks++; if (bad !== -1) begin n_errors++; $display("FAIL wrap_addr: got bad index %0d of %0d reads expected -1", bad, iss_q.size()); end
    n_checks++; if (acc_q.size() !== 8 || first_bad(2044, 8) !== -1) begin n_errors++; $display("FAIL wrap_data: got %0d bytes bad %0d expected 8 -1", acc_q.size(), first_bad(2044, 8)); end
    n_checks++; if (acc_q.size() > 4 && acc_q[4] !== 8'd0) begin n_errors++; $display("FAIL wrap_byte4: got %0d expected 0", acc_q[4]); end
  endtask

  task automatic test_len_zero();
    bit ok;
    start_xfer(123, 0);
    wait_done(20, 1'b0, ok);
    n_checks++; if (done_rel !== 1) begin n_errors++; $display("FAIL zero_done_time: got rel %0d expected 1", done_rel); end
    repeat (3) @(negedge clk);
    n_checks++; if (dv_cnt !== 0 || issued !== 0) begin n_errors++; $display("FAIL zero_no_data: got dvalid %0d reads %0d expected 0 0", dv_cnt, issued); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_len_max();
    bit ok;
    int sa;
    sa = $urandom_range(0, PAGE - 1);
    start_xfer(sa, 4095);
    wait_done(2300, 1'b0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL max_timeout: got no Done expected Done"); end
    n_checks++; if (acc_q.size() !== PAGE) begin n_errors++; $display("FAIL max_count: got %0d expected %0d", acc_q.size(), PAGE); end
    n_checks++; if (first_bad(sa, PAGE) !== -1) begin n_errors++; $display("FAIL max_data: got bad index %0d expected -1", first_bad(sa, PAGE)); end
  endtask

  task automatic test_random_stall();
    bit ok;
    int sa, len;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      sa  = $urandom_range(0, PAGE - 1);
      len = (it == 0) ? 64 : $urandom_range(1, 200);
      start_xfer(sa, len);
      wait_done(len * 6 + 50, 1'b1, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_timeout it%0d: got no Done expected Done", it); end
      n_checks++; if (acc_q.size() !== len) begin n_errors++; $display("FAIL stall_count it%0d: got %0d expected %0d", it, acc_q.size(), len); end
      n_checks++; if (first_bad(sa, len) !== -1) begin n_errors++; $display("FAIL stall_data it%0d: got bad index %0d expected -1", it, first_bad(sa, len)); end
      n_checks++; if (stall_viol !== 0) begin n_errors++; $display("FAIL stall_stable it%0d: got %0d changes expected 0", it, stall_viol); end
      n_checks++; if (held_viol !== 0) begin n_errors++; $display("FAIL stall_overissue it%0d: got %0d expected 0", it, held_viol); end
    end
    fill_ramp();
  endtask

  task automatic test_start_rules();
    bit ok;
    Abort = 1'b1;
    start_xfer(7, 3);
    Abort = 1'b0;
    wait_done(50, 1'b0, ok);
    n_checks++; if (acc_q.size() !== 3 || first_bad(7, 3) !== -1) begin n_errors++; $display("FAIL start_abort_together: got %0d bytes bad %0d expected 3 -1", acc_q.size(), first_bad(7, 3)); end
    start_xfer(100, 20);
    repeat (4) @(posedge clk);
    #1; Start = 1'b1; StartAddr = AW'(500); Length = (AW+1)'(3);
    @(posedge clk); #1; Start = 1'b0;
    wait_done(100, 1'b0, ok);
    n_checks++; if (acc_q.size() !== 20 || first_bad(100, 20) !== -1) begin n_errors++; $display("FAIL start_while_busy: got %0d bytes bad %0d expected 20 -1", acc_q.size(), first_bad(100, 20)); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== 1 || Busy !== 1'b0 || issued !== 20) begin n_errors++; $display("FAIL start_busy_tail: got done %0d busy %b reads %0d expected 1 0 20", done_cnt, Busy, issued); end
  endtask

  task automatic test_abort();
    bit ok;
    start_xfer(0, 100);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (accepted >= 10) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_reach10: got %0d bytes expected 10", accepted); end
    @(posedge clk); #1; Abort = 1'b1;
    @(posedge clk); #1; Abort = 1'b0;
    @(negedge clk);
    n_checks++; if (DValid !== 1'b0) begin n_errors++; $display("FAIL abort_dvalid: got %b expected 0", DValid); end
    n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL abort_done_pulse: got %b expected 1", Done); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== 1 || Busy !== 1'b0) begin n_errors++; $display("FAIL abort_once: got done %0d busy %b expected 1 0", done_cnt, Busy); end
    n_checks++; if (acc_q.size() < 10 || acc_q.size() >= 100 || dv_cnt !== acc_q.size() || first_bad(0, acc_q.size()) !== -1) begin n_errors++; $display("FAIL abort_prefix: got %0d bytes %0d valid bad %0d expected clean prefix", acc_q.size(), dv_cnt, first_bad(0, acc_q.size())); end
    start_xfer(0, 4);
    wait_done(50, 1'b0, ok);
    n_checks++; if (acc_q.size() !== 4 || first_bad(0, 4) !== -1) begin n_errors++; $display("FAIL abort_next_xfer: got %0d bytes bad %0d expected 4 -1", acc_q.size(), first_bad(0, 4)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sa;
    start_xfer(40, 32);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepted >= 5) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rstmid_reach5: got %0d bytes expected 5", accepted); end
    @(posedge clk); #1; Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({Busy, Done, DValid, BufClkEn, BufWr} !== 5'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got %b expected 00000", {Busy, Done, DValid, BufClkEn, BufWr}); end
    n_checks++; if (BufAddr !== '0 || DOut !== '0) begin n_errors++; $display("FAIL rstmid_data: got addr %0d dout %0d expected 0 0", BufAddr, DOut); end
    repeat (2) @(posedge clk);
    #1; Reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== 0 || DValid !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_done: got done %0d dvalid %b expected 0 0", done_cnt, DValid); end
    sa = $urandom_range(0, PAGE - 1);
    start_xfer(sa, 6);
    wait_done(50, 1'b0, ok);
    n_checks++; if (acc_q.size() !== 6 || first_bad(sa, 6) !== -1) begin n_errors++; $display("FAIL rstmid_next_xfer: got %0d bytes bad %0d expected 6 -1", acc_q.size(), first_bad(sa, 6)); end
  endtask

  initial begin
    fill_ramp();
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_len_max();
    test_random_stall();
    test_start_rules();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
